// File: rtl/rf_pkg.sv
// Shared defaults, index type and port-slice helper for the multiport register file.
package rf_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_NREG   = 8;
  localparam int DEFAULT_NREAD  = 2;
  localparam int DEFAULT_AW     = $clog2(DEFAULT_NREG);

  typedef logic [DEFAULT_AW-1:0] reg_idx_t;

  // Low bit of a port's field inside a flattened multi-port bus.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard: alloc sets, write clears (alloc wins on a tie), sticky WAW error.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREG = DEFAULT_NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_sel,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_sel,
  output logic [NREG-1:0] busy,
  output logic            err
);

  logic [NREG-1:0] busy_nxt;
  logic            err_set;

  always_comb begin
    busy_nxt = busy;
    if (wr_en)
      busy_nxt[wr_sel] = 1'b0;
    if (alloc_en)
      busy_nxt[alloc_sel] = 1'b1;
  end

  // A retiring write to the same register makes the re-allocation legal.
  assign err_set = alloc_en && busy[alloc_sel] && !(wr_en && (wr_sel == alloc_sel));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      err  <= err | err_set;
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised register file with NREAD combinational read ports and a pending scoreboard.
// Optional write-to-read bypass is enabled by defining RF_BYPASS_EN.
module rf_multiport
  import rf_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int NREG   = DEFAULT_NREG,
  parameter  int NREAD  = DEFAULT_NREAD,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*AW-1:0]     rd_sel,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_sel,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    alloc_en,
  input  logic [AW-1:0]           alloc_sel,
  output logic                    err
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_sel] <= wr_data;
    end
  end

  rf_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .alloc_en  (alloc_en),
    .alloc_sel (alloc_sel),
    .busy      (busy),
    .err       (err)
  );

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] sel;
    assign sel = rd_sel[slice_lo(p, AW) +: AW];
`ifdef RF_BYPASS_EN
    logic hit;
    assign hit = wr_en && (sel == wr_sel);
    assign rd_data[slice_lo(p, DATA_W) +: DATA_W] = hit ? wr_data : regs[sel];
    // A same-cycle alloc of the register being written keeps it pending.
    assign rd_busy[p] = hit ? (alloc_en && (alloc_sel == sel)) : busy[sel];
`else
    assign rd_data[slice_lo(p, DATA_W) +: DATA_W] = regs[sel];
    assign rd_busy[p] = busy[sel];
`endif
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed self-checking bench for rf_multiport: default 8x16x2 instance and a 16x32x3 instance.
module tb_rf_multiport;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 8 x 16, two read ports
  logic [5:0]  rd_sel_a = '0;
  logic [31:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic        wr_en_a = 1'b0;
  logic [2:0]  wr_sel_a = '0;
  logic [15:0] wr_data_a = '0;
  logic        alloc_en_a = 1'b0;
  logic [2:0]  alloc_sel_a = '0;
  logic        err_a;

  // Instance B: 16 x 32, three read ports
  logic [11:0] rd_sel_b = '0;
  logic [95:0] rd_data_b;
  logic [2:0]  rd_busy_b;
  logic        wr_en_b = 1'b0;
  logic [3:0]  wr_sel_b = '0;
  logic [31:0] wr_data_b = '0;
  logic        alloc_en_b = 1'b0;
  logic [3:0]  alloc_sel_b = '0;
  logic        err_b;

  int n_cmp = 0;
  int n_bad = 0;

  rf_multiport #(.DATA_W(16), .NREG(8), .NREAD(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_sel(rd_sel_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en_a), .wr_sel(wr_sel_a), .wr_data(wr_data_a),
    .alloc_en(alloc_en_a), .alloc_sel(alloc_sel_a), .err(err_a)
  );

  rf_multiport #(.DATA_W(32), .NREG(16), .NREAD(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_sel(rd_sel_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en_b), .wr_sel(wr_sel_b), .wr_data(wr_data_b),
    .alloc_en(alloc_en_b), .alloc_sel(alloc_sel_b), .err(err_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 8; s++) begin
      rd_sel_a = {3'(7 - s), 3'(s)};
      #1;
      n_cmp++;
      if (rd_data_a !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_data sel=%0d got=%h exp=%h", s, rd_data_a, 32'h0);
      end
      n_cmp++;
      if (rd_busy_a !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_busy sel=%0d got=%b exp=00", s, rd_busy_a);
      end
    end
    n_cmp++;
    if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset_err_a got=%b exp=0", err_a); end
    n_cmp++;
    if ({err_b, rd_busy_b, rd_data_b} !== 100'h0) begin
      n_bad++;
      $display("FAIL reset_b got err=%b busy=%b data=%h exp all 0", err_b, rd_busy_b, rd_data_b);
    end
  endtask

  task automatic test_write_read();
    rd_sel_a = {3'd3, 3'd3};
    wr_en_a = 1'b1; wr_sel_a = 3'd3; wr_data_a = 16'hBEEF;
    #1;
    n_cmp++;
    if (rd_data_a !== (BYP ? 32'hBEEF_BEEF : 32'h0)) begin
      n_bad++;
      $display("FAIL wr_cycle_read got=%h exp=%h", rd_data_a, (BYP ? 32'hBEEF_BEEF : 32'h0));
    end
    tick();
    wr_en_a = 1'b0;
    #1;
    n_cmp++;
    if (rd_data_a !== 32'hBEEF_BEEF) begin
      n_bad++;
      $display("FAIL wr_next_read got=%h exp=%h", rd_data_a, 32'hBEEF_BEEF);
    end
  endtask

  task automatic test_alloc();
    rd_sel_a = {3'd3, 3'd5};
    alloc_en_a = 1'b1; alloc_sel_a = 3'd5;
    #1;
    n_cmp++;
    if (rd_busy_a !== 2'b00) begin
      n_bad++;
      $display("FAIL alloc_no_forward got=%b exp=00", rd_busy_a);
    end
    tick();
    alloc_en_a = 1'b0;
    #1;
    n_cmp++;
    if (rd_busy_a !== 2'b01) begin
      n_bad++;
      $display("FAIL alloc_busy got=%b exp=01", rd_busy_a);
    end
    wr_en_a = 1'b1; wr_sel_a = 3'd5; wr_data_a = 16'h1234;
    #1;
    n_cmp++;
    if ({rd_busy_a[0], rd_data_a[15:0]} !== (BYP ? 17'h0_1234 : 17'h1_0000)) begin
      n_bad++;
      $display("FAIL retire_wr_cycle got busy=%b data=%h exp=%h", rd_busy_a[0], rd_data_a[15:0],
               (BYP ? 17'h0_1234 : 17'h1_0000));
    end
    tick();
    wr_en_a = 1'b0;
    #1;
    n_cmp++;
    if ({err_a, rd_busy_a, rd_data_a} !== 35'h0_BEEF_1234) begin
      n_bad++;
      $display("FAIL retire_after got err=%b busy=%b data=%h exp err=0 busy=00 data=BEEF1234",
               err_a, rd_busy_a, rd_data_a);
    end
  endtask

  task automatic test_alloc_write_same();
    rd_sel_a = {3'd2, 3'd2};
    alloc_en_a = 1'b1; alloc_sel_a = 3'd2;
    wr_en_a = 1'b1; wr_sel_a = 3'd2; wr_data_a = 16'h00AA;
    #1;
    n_cmp++;
    if ({rd_busy_a, rd_data_a} !== (BYP ? 34'h3_00AA_00AA : 34'h0)) begin
      n_bad++;
      $display("FAIL same_edge_cycle got busy=%b data=%h", rd_busy_a, rd_data_a);
    end
    tick();
    alloc_en_a = 1'b0; wr_en_a = 1'b0;
    #1;
    n_cmp++;
    if ({err_a, rd_busy_a, rd_data_a} !== 35'h3_00AA_00AA) begin
      n_bad++;
      $display("FAIL same_edge_after got err=%b busy=%b data=%h exp err=0 busy=11 data=00AA00AA",
               err_a, rd_busy_a, rd_data_a);
    end
    alloc_en_a = 1'b1; alloc_sel_a = 3'd2;
    tick();
    alloc_en_a = 1'b0;
    #1;
    n_cmp++;
    if (err_a !== 1'b1) begin n_bad++; $display("FAIL double_alloc_err got=%b exp=1", err_a); end
    wr_en_a = 1'b1; wr_sel_a = 3'd2; wr_data_a = 16'h0BB0;
    tick();
    wr_sel_a = 3'd4; wr_data_a = 16'h4004;
    tick();
    wr_en_a = 1'b0;
    #1;
    n_cmp++;
    if ({err_a, rd_busy_a, rd_data_a} !== 35'h4_0BB0_0BB0) begin
      n_bad++;
      $display("FAIL err_sticky got err=%b busy=%b data=%h exp err=1 busy=00 data=0BB00BB0",
               err_a, rd_busy_a, rd_data_a);
    end
  endtask

  task automatic test_reset_mid();
    rd_sel_a = {3'd3, 3'd1};
    alloc_en_a = 1'b1; alloc_sel_a = 3'd1;
    tick();
    alloc_en_a = 1'b0;
    #1;
    n_cmp++;
    if ({err_a, rd_busy_a, rd_data_a[31:16]} !== 19'h5_BEEF) begin
      n_bad++;
      $display("FAIL pre_reset got err=%b busy=%b data1=%h exp err=1 busy=01 data1=BEEF",
               err_a, rd_busy_a, rd_data_a[31:16]);
    end
    wr_en_a = 1'b1; wr_sel_a = 3'd1; wr_data_a = 16'h5555;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({err_a, rd_busy_a, rd_data_a[31:16]} !== 19'h0) begin
      n_bad++;
      $display("FAIL async_reset got err=%b busy=%b data1=%h exp all 0",
               err_a, rd_busy_a, rd_data_a[31:16]);
    end
    tick();
    wr_en_a = 1'b0;
    #1;
    n_cmp++;
    if (rd_data_a !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_edge_write got=%h exp=%h", rd_data_a, 32'h0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_retire_realloc();
    rd_sel_a = {3'd5, 3'd4};
    alloc_en_a = 1'b1; alloc_sel_a = 3'd4;
    tick();
    wr_en_a = 1'b1; wr_sel_a = 3'd4; wr_data_a = 16'h4444;
    tick();
    alloc_en_a = 1'b0; wr_en_a = 1'b0;
    #1;
    n_cmp++;
    if ({err_a, rd_busy_a[0], rd_data_a[15:0]} !== 18'h1_4444) begin
      n_bad++;
      $display("FAIL realloc got err=%b busy=%b data=%h exp err=0 busy=1 data=4444",
               err_a, rd_busy_a[0], rd_data_a[15:0]);
    end
    alloc_en_a = 1'b1; alloc_sel_a = 3'd5;
    wr_en_a = 1'b1; wr_sel_a = 3'd4; wr_data_a = 16'h4545;
    tick();
    alloc_en_a = 1'b0; wr_en_a = 1'b0;
    #1;
    n_cmp++;
    if ({err_a, rd_busy_a, rd_data_a} !== 35'h2_0000_4545) begin
      n_bad++;
      $display("FAIL split_regs got err=%b busy=%b data=%h exp err=0 busy=10 data=00004545",
               err_a, rd_busy_a, rd_data_a);
    end
  endtask

  task automatic test_cross_write();
    wr_en_a = 1'b1; wr_sel_a = 3'd6; wr_data_a = 16'h6666;
    tick();
    wr_sel_a = 3'd0; wr_data_a = 16'h0A0A;
    tick();
    rd_sel_a = {3'd0, 3'd6};
    wr_sel_a = 3'd7; wr_data_a = 16'hFFFF;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (rd_data_a !== 32'h0A0A_6666) begin
        n_bad++;
        $display("FAIL cross_write cyc=%0d got=%h exp=%h", c, rd_data_a, 32'h0A0A_6666);
      end
      tick();
    end
    wr_en_a = 1'b0;
    rd_sel_a = {3'd0, 3'd7};
    #1;
    n_cmp++;
    if (rd_data_a !== 32'h0A0A_FFFF) begin
      n_bad++;
      $display("FAIL reg7_value got=%h exp=%h", rd_data_a, 32'h0A0A_FFFF);
    end
  endtask

  task automatic test_param_large();
    rd_sel_b = {4'd15, 4'd9, 4'd13};
    wr_en_b = 1'b1; wr_sel_b = 4'd13; wr_data_b = 32'hDEAD_BEEF;
    alloc_en_b = 1'b1; alloc_sel_b = 4'd9;
    tick();
    wr_en_b = 1'b0; alloc_en_b = 1'b0;
    #1;
    n_cmp++;
    if ({err_b, rd_busy_b, rd_data_b} !== {1'b0, 3'b010, 64'h0, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL large_rw got err=%b busy=%b data=%h exp err=0 busy=010 data=..DEADBEEF",
               err_b, rd_busy_b, rd_data_b);
    end
    alloc_en_b = 1'b1; alloc_sel_b = 4'd9;
    tick();
    alloc_en_b = 1'b0;
    #1;
    n_cmp++;
    if (err_b !== 1'b1) begin n_bad++; $display("FAIL large_err got=%b exp=1", err_b); end
    wr_en_b = 1'b1; wr_sel_b = 4'd13; wr_data_b = 32'h1234_5678;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({err_b, rd_busy_b} !== 4'b0000) begin
      n_bad++;
      $display("FAIL large_async_reset got err=%b busy=%b exp 0/000", err_b, rd_busy_b);
    end
    tick();
    wr_en_b = 1'b0;
    #1;
    n_cmp++;
    if (rd_data_b !== 96'h0) begin
      n_bad++;
      $display("FAIL large_reset_data got=%h exp=0", rd_data_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_alloc();
    test_alloc_write_same();
    test_reset_mid();
    test_retire_realloc();
    test_cross_write();
    test_param_large();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
